// File: rtl/gray_pkg.sv
// Shared types and Gray/binary helpers for the Gray-code sequence generator.
// Helpers work on a wide word; callers zero-extend the input and truncate the result to their width.
package gray_pkg;

  localparam int GSG_MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    DONE    = 2'd2
  } gsg_state_t;

  function automatic logic [GSG_MAX_W-1:0] bin2gray(input logic [GSG_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero-extended upper bits leave the low bits unaffected.
  function automatic logic [GSG_MAX_W-1:0] gray2bin(input logic [GSG_MAX_W-1:0] g);
    logic [GSG_MAX_W-1:0] b;
    b[GSG_MAX_W-1] = g[GSG_MAX_W-1];
    for (int i = GSG_MAX_W - 2; i >= 0; i--) begin
      b[i] = g[i] ^ b[i+1];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_seq_gen_gray2bin_w.sv
// Combinational Gray-to-binary decoder used on the load path.
// Same bit equations as the downstream decoder: b[W-1]=g[W-1], b[i]=g[i]^b[i+1].
module gray2bin_w #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] b
);

  // Prefix XOR chain from the MSB downward.
  always_comb begin
    b = {WIDTH{1'b0}};
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = g[i] ^ b[i+1];
    end
  end

endmodule

// File: rtl/gray_seq_gen.sv
// Up/down Gray-code sequence generator with a registered valid/ready output.
// The count steps once per accepted word; load takes a Gray start point; wrap or saturate at terminal.
module gray_seq_gen
  import gray_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] g_out,
  output logic             g_valid,
  input  logic             g_ready,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_C = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

  gsg_state_t       state_r;
  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] g_out_r;
  logic             g_valid_r;
  logic             tc_r;

  logic [WIDTH-1:0] load_bin_s;
  logic [WIDTH-1:0] step_bin_s;
  logic [WIDTH-1:0] step_gray_s;
  logic             xfer_s;
  logic             terminal_s;

  gray2bin_w #(.WIDTH(WIDTH)) u_load_dec (
    .g (load_gray),
    .b (load_bin_s)
  );

  // Transfer detect, terminal test on the word being presented, and next count/Gray word.
  always_comb begin
    xfer_s      = g_valid_r & g_ready;
    terminal_s  = up ? (cnt_r == ONES_C) : (cnt_r == ZERO_C);
    step_bin_s  = up ? (cnt_r + ONE_C) : (cnt_r - ONE_C);
    step_gray_s = WIDTH'(bin2gray(GSG_MAX_W'(step_bin_s)));
  end

  // Sequencer: count, Gray word, valid and terminal pulse all registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= ZERO_C;
      g_out_r   <= ZERO_C;
      g_valid_r <= 1'b0;
      tc_r      <= 1'b0;
    end else begin
      // A transfer coincident with load still counts toward tc.
      tc_r <= xfer_s & terminal_s;
      if (load) begin
        cnt_r     <= load_bin_s;
        g_out_r   <= load_gray;
        state_r   <= IDLE;
        g_valid_r <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (en) begin
              state_r   <= PRESENT;
              g_valid_r <= 1'b1;
            end else begin
              state_r   <= IDLE;
              g_valid_r <= 1'b0;
            end
          end
          PRESENT: begin
            if (xfer_s) begin
              if (terminal_s && (WRAP == 1'b0)) begin
                state_r   <= DONE;
                g_valid_r <= 1'b0;
              end else begin
                cnt_r     <= step_bin_s;
                g_out_r   <= step_gray_s;
                state_r   <= en ? PRESENT : IDLE;
                g_valid_r <= en;
              end
            end else begin
              // Word stays on the bus until accepted, regardless of en.
              state_r   <= PRESENT;
              g_valid_r <= 1'b1;
            end
          end
          DONE: begin
            state_r   <= DONE;
            g_valid_r <= 1'b0;
          end
          default: begin
            state_r   <= IDLE;
            g_valid_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign g_out   = g_out_r;
  assign g_valid = g_valid_r;
  assign tc      = tc_r;

endmodule

// File: tb/tb_gray_seq_gen.sv
// Self-checking bench for gray_seq_gen: scoreboard of accepted words plus per-scenario tasks.
// A wrapping instance is scoreboarded; a saturating instance shares the stimulus.
module tb_gray_seq_gen;

  logic       clk = 1'b0;
  logic       rst, en, up, load, g_ready;
  logic [3:0] load_gray;
  logic [3:0] g_out, s_g_out;
  logic       g_valid, tc, s_g_valid, s_tc;

  int checks = 0;
  int failures = 0;

  logic [3:0] exp_q[$];
  bit         mon_en = 1'b0;
  bit         chain_ok = 1'b0;
  bit         tc_exp = 1'b0;
  bit         last_up = 1'b0;
  logic [3:0] last_b = 4'd0;

  gray_seq_gen #(.WIDTH(4), .WRAP(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
    .g_out(g_out), .g_valid(g_valid), .g_ready(g_ready), .tc(tc)
  );

  gray_seq_gen #(.WIDTH(4), .WRAP(1'b0)) dut_s (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
    .g_out(s_g_out), .g_valid(s_g_valid), .g_ready(g_ready), .tc(s_tc)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] tb_gray(input int v);
    logic [3:0] b;
    b = v[3:0];
    return b ^ {1'b0, b[3:1]};
  endfunction

  function automatic logic [3:0] tb_g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    b[2] = g[2] ^ b[3];
    b[1] = g[1] ^ b[2];
    b[0] = g[0] ^ b[1];
    return b;
  endfunction

  // Scoreboard: inputs are stable at the falling edge, so valid&ready here is the transfer at the next rising edge.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [3:0] w, b, eb;
      checks++;
      if (tc !== tc_exp) begin
        failures++;
        $display("FAIL tc_pulse: got %b expected %b at %0t", tc, tc_exp, $time);
      end
      tc_exp = 1'b0;
      if (!rst && g_valid === 1'b1 && g_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected: got word %b expected none at %0t", g_out, $time);
        end else begin
          w = exp_q.pop_front();
          if (g_out !== w) begin
            failures++;
            $display("FAIL sb_word: got %b expected %b at %0t", g_out, w, $time);
          end
          b = tb_g2b(g_out);
          if (chain_ok) begin
            eb = last_up ? last_b + 4'd1 : last_b - 4'd1;
            checks++;
            if (b !== eb) begin
              failures++;
              $display("FAIL sb_step: got bin %0d expected %0d at %0t", b, eb, $time);
            end
          end
          last_b   = b;
          last_up  = up;
          chain_ok = 1'b1;
          tc_exp   = up ? (tb_g2b(w) == 4'hF) : (tb_g2b(w) == 4'h0);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    tick();
    rst = 1'b1; en = 1'b0; load = 1'b0; g_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chain_ok = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_gray = 4'd0; g_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks += 4;
    if (g_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b expected 0", g_valid); end
    if (g_out !== 4'b0000) begin failures++; $display("FAIL rst_gout: got %b expected 0000", g_out); end
    if (tc !== 1'b0) begin failures++; $display("FAIL rst_tc: got %b expected 0", tc); end
    if (s_g_valid !== 1'b0 || s_g_out !== 4'b0000) begin
      failures++; $display("FAIL rst_sat: got valid %b out %b expected 0 0000", s_g_valid, s_g_out);
    end
    tc_exp = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_up_wrap;
    up = 1'b1; g_ready = 1'b1;
    for (int i = 0; i < 16; i++) exp_q.push_back(tb_gray(i));
    exp_q.push_back(tb_gray(0));
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (g_valid !== 1'b0) begin failures++; $display("FAIL up_latency: got valid %b expected 0", g_valid); end
    tick();
    checks++;
    if (g_valid !== 1'b1 || g_out !== 4'b0000) begin
      failures++; $display("FAIL up_first: got valid %b out %b expected 1 0000", g_valid, g_out);
    end
    for (int i = 0; i < 16; i++) tick();
    en = 1'b0;
    tick();
    tick();
    checks++;
    if (g_valid !== 1'b0 || exp_q.size() != 0) begin
      failures++; $display("FAIL up_end: got valid %b pending %0d expected 0 0", g_valid, exp_q.size());
    end
  endtask

  task automatic test_down_wrap;
    do_reset();
    up = 1'b0;
    exp_q.push_back(4'b0000); exp_q.push_back(4'b1000);
    exp_q.push_back(4'b1001); exp_q.push_back(4'b1011);
    en = 1'b1;
    tick();
    checks++;
    if (g_valid !== 1'b1 || g_out !== 4'b0000) begin
      failures++; $display("FAIL down_first: got valid %b out %b expected 1 0000", g_valid, g_out);
    end
    tick();
    checks++;
    if (g_out !== 4'b1000) begin failures++; $display("FAIL down_wrap: got %b expected 1000", g_out); end
    tick();
    tick();
    en = 1'b0;
    tick();
    tick();
    checks++;
    if (g_valid !== 1'b0 || exp_q.size() != 0) begin
      failures++; $display("FAIL down_end: got valid %b pending %0d expected 0 0", g_valid, exp_q.size());
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    up = 1'b1;
    exp_q.push_back(4'b0000); exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0011); exp_q.push_back(4'b0010);
    en = 1'b1;
    tick();
    tick();
    tick();
    g_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 1) en = 1'b0;
      checks++;
      if (g_valid !== 1'b1 || g_out !== 4'b0011) begin
        failures++; $display("FAIL bp_hold: got valid %b out %b expected 1 0011", g_valid, g_out);
      end
    end
    en = 1'b1;
    g_ready = 1'b1;
    tick();
    checks++;
    if (g_valid !== 1'b1 || g_out !== 4'b0010) begin
      failures++; $display("FAIL bp_release: got valid %b out %b expected 1 0010", g_valid, g_out);
    end
    en = 1'b0;
    tick();
    tick();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL bp_end: got pending %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_load;
    do_reset();
    up = 1'b1;
    exp_q.push_back(4'b0000); exp_q.push_back(4'b0001);
    en = 1'b1;
    tick();
    tick();
    load = 1'b1; load_gray = 4'b0111;
    tick();
    load = 1'b0;
    chain_ok = 1'b0;
    exp_q.push_back(4'b0111); exp_q.push_back(4'b0101);
    checks++;
    if (g_valid !== 1'b0 || g_out !== 4'b0111) begin
      failures++; $display("FAIL load_drop: got valid %b out %b expected 0 0111", g_valid, g_out);
    end
    tick();
    checks++;
    if (g_valid !== 1'b1 || g_out !== 4'b0111) begin
      failures++; $display("FAIL load_first: got valid %b out %b expected 1 0111", g_valid, g_out);
    end
    tick();
    checks++;
    if (g_out !== 4'b0101) begin failures++; $display("FAIL load_next: got %b expected 0101", g_out); end
    en = 1'b0;
    tick();
    tick();
    checks++;
    if (g_valid !== 1'b0 || exp_q.size() != 0) begin
      failures++; $display("FAIL load_end: got valid %b pending %0d expected 0 0", g_valid, exp_q.size());
    end
  endtask

  task automatic test_saturate;
    up = 1'b1; g_ready = 1'b1; en = 1'b0;
    load = 1'b1; load_gray = 4'b1001;
    tick();
    load = 1'b0;
    chain_ok = 1'b0;
    exp_q.push_back(4'b1001); exp_q.push_back(4'b1000); exp_q.push_back(4'b0000);
    checks++;
    if (s_g_valid !== 1'b0 || s_g_out !== 4'b1001) begin
      failures++; $display("FAIL sat_load: got valid %b out %b expected 0 1001", s_g_valid, s_g_out);
    end
    en = 1'b1;
    tick();
    checks++;
    if (s_g_valid !== 1'b1 || s_g_out !== 4'b1001) begin
      failures++; $display("FAIL sat_first: got valid %b out %b expected 1 1001", s_g_valid, s_g_out);
    end
    tick();
    checks++;
    if (s_g_out !== 4'b1000 || s_tc !== 1'b0) begin
      failures++; $display("FAIL sat_term: got out %b tc %b expected 1000 0", s_g_out, s_tc);
    end
    en = 1'b0;
    tick();
    checks++;
    if (s_tc !== 1'b1 || s_g_valid !== 1'b0 || s_g_out !== 4'b1000) begin
      failures++; $display("FAIL sat_tc: got tc %b valid %b out %b expected 1 0 1000", s_tc, s_g_valid, s_g_out);
    end
    en = 1'b1;
    tick();
    checks++;
    if (s_tc !== 1'b0 || s_g_valid !== 1'b0 || g_out !== 4'b0000 || g_valid !== 1'b1) begin
      failures++;
      $display("FAIL sat_done: got s_tc %b s_valid %b w_out %b w_valid %b expected 0 0 0000 1", s_tc, s_g_valid, g_out, g_valid);
    end
    en = 1'b0;
    tick();
    checks++;
    if (s_g_valid !== 1'b0) begin failures++; $display("FAIL sat_hold: got valid %b expected 0", s_g_valid); end
    load = 1'b1; load_gray = 4'b0011;
    tick();
    load = 1'b0;
    chain_ok = 1'b0;
    exp_q.push_back(4'b0011);
    en = 1'b1;
    checks++;
    if (s_g_valid !== 1'b0 || s_g_out !== 4'b0011) begin
      failures++; $display("FAIL sat_exit_load: got valid %b out %b expected 0 0011", s_g_valid, s_g_out);
    end
    tick();
    checks++;
    if (s_g_valid !== 1'b1 || s_g_out !== 4'b0011) begin
      failures++; $display("FAIL sat_exit: got valid %b out %b expected 1 0011", s_g_valid, s_g_out);
    end
    en = 1'b0;
    tick();
    tick();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL sat_end: got pending %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_midstream;
    g_ready = 1'b0;
    en = 1'b1;
    tick();
    checks++;
    if (g_valid !== 1'b1 || s_g_valid !== 1'b1) begin
      failures++; $display("FAIL mid_present: got valid %b/%b expected 1/1", g_valid, s_g_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b0; g_ready = 1'b1;
    chain_ok = 1'b0;
    checks++;
    if (g_valid !== 1'b0 || g_out !== 4'b0000 || tc !== 1'b0 || s_g_valid !== 1'b0 || s_g_out !== 4'b0000) begin
      failures++;
      $display("FAIL mid_reset: got valid %b out %b tc %b s_valid %b s_out %b expected 0 0000 0 0 0000", g_valid, g_out, tc, s_g_valid, s_g_out);
    end
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_backpressure();
    test_load();
    test_saturate();
    test_reset_midstream();
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
